// File: rtl/trace_stream_receiver.sv
// Trace stream receiver: buffers AXI-Stream trace beats in a 2-entry FIFO,
// unpacks them into instr/delta/pc/events records, and tracks frame boundaries.
// It also rebuilds an absolute timestamp from the per-record clock deltas.
// Optional statistics counters are enabled by defining TRACE_STREAM_RECEIVER_STATS_EN.
// When that macro is undefined, frame_count and record_count read as 0.
module trace_stream_receiver #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DELTA_WIDTH = 64,
  parameter int unsigned PC_WIDTH    = 64,
  localparam int unsigned EVT_WIDTH  = DATA_WIDTH - INSTR_WIDTH - DELTA_WIDTH - PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // Trace packet stream
  input  logic                   S_AXIS_tvalid,
  output logic                   S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                   S_AXIS_tlast,
  // Synchronous flush
  input  logic                   clear,
  // Decoded record
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [DELTA_WIDTH-1:0] out_delta,
  output logic [EVT_WIDTH-1:0]   out_events,
  output logic [DELTA_WIDTH-1:0] out_timestamp,
  output logic                   out_first,
  output logic                   out_last,
  // Statistics
  output logic [31:0]            frame_count,
  output logic [31:0]            record_count
);

  localparam int unsigned PcLsb    = EVT_WIDTH;
  localparam int unsigned DeltaLsb = EVT_WIDTH + PC_WIDTH;
  localparam int unsigned InstrLsb = EVT_WIDTH + PC_WIDTH + DELTA_WIDTH;

  typedef enum logic {StIdle, StInFrame} state_e;

  // FIFO storage: {tlast, tdata}
  logic [DATA_WIDTH:0]    mem_q [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             occ_q, occ_d;
  // Low during reset and until the first edge after release
  logic                   rdy_q;
  logic [DELTA_WIDTH-1:0] acc_q, acc_d;
  state_e                 state_q, state_d;

  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH:0]    head;
  logic [DATA_WIDTH-1:0]  head_data;

  assign S_AXIS_tready = rdy_q & (occ_q < 2'd2);
  assign out_valid     = (occ_q != 2'd0);
  assign push          = S_AXIS_tvalid & S_AXIS_tready;
  assign pop           = out_valid & out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign head_data = head[DATA_WIDTH-1:0];

  assign out_instr     = head_data[InstrLsb +: INSTR_WIDTH];
  assign out_delta     = head_data[DeltaLsb +: DELTA_WIDTH];
  assign out_pc        = head_data[PcLsb +: PC_WIDTH];
  assign out_events    = head_data[EVT_WIDTH-1:0];
  assign out_last      = head[DATA_WIDTH];
  assign out_timestamp = acc_q + out_delta;
  assign out_first     = out_valid & (state_q == StIdle);

  // Payload storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= {S_AXIS_tlast, S_AXIS_tdata};
    end
  end

  // Next-state for FIFO pointers/occupancy, timestamp accumulator and frame FSM
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    acc_d    = acc_q;
    state_d  = state_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
      acc_d    = '0;
      state_d  = StIdle;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        acc_d    = acc_q + out_delta;
        state_d  = out_last ? StIdle : StInFrame;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      state_q  <= StIdle;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rdy_q    <= 1'b1;
      acc_q    <= acc_d;
      state_q  <= state_d;
    end
  end

`ifdef TRACE_STREAM_RECEIVER_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] record_cnt_q, record_cnt_d;

  // Counter next-state; both wrap naturally at 2^32
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    record_cnt_d = record_cnt_q;
    if (clear) begin
      frame_cnt_d  = '0;
      record_cnt_d = '0;
    end else if (pop) begin
      record_cnt_d = record_cnt_q + 32'd1;
      if (out_last) begin
        frame_cnt_d = frame_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      record_cnt_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      record_cnt_q <= record_cnt_d;
    end
  end

  assign frame_count  = frame_cnt_q;
  assign record_count = record_cnt_q;
`else
  assign frame_count  = 32'd0;
  assign record_count = 32'd0;
`endif

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Self-checking bench for trace_stream_receiver (default parameters).
// Reference model: a queue of buffered beats plus running time/frame bookkeeping.
module tb_trace_stream_receiver;

`ifdef TRACE_STREAM_RECEIVER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [511:0] tdata = '0;
  logic         tlast = 1'b0;
  logic         clear = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_instr;
  logic [63:0]  out_pc;
  logic [63:0]  out_delta;
  logic [351:0] out_events;
  logic [63:0]  out_timestamp;
  logic         out_first;
  logic         out_last;
  logic [31:0]  frame_count;
  logic [31:0]  record_count;

  trace_stream_receiver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .S_AXIS_tvalid (tvalid),
    .S_AXIS_tready (tready),
    .S_AXIS_tdata  (tdata),
    .S_AXIS_tlast  (tlast),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_delta     (out_delta),
    .out_events    (out_events),
    .out_timestamp (out_timestamp),
    .out_first     (out_first),
    .out_last      (out_last),
    .frame_count   (frame_count),
    .record_count  (record_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } beat_t;

  beat_t       mq[$];
  logic [63:0] m_acc = '0;
  bit          m_in_frame = 1'b0;
  logic [31:0] m_frames = '0;
  logic [31:0] m_records = '0;
  bit          m_rdy = 1'b0;

  function automatic logic [511:0] mk(input logic [31:0] instr, input logic [63:0] delta,
                                      input logic [63:0] pc);
    logic [351:0] ev;
    for (int k = 0; k < 11; k++) ev[k*32 +: 32] = $urandom();
    return {instr, delta, pc, ev};
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
    return Stats ? v : 32'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_acc = '0;
    m_in_frame = 1'b0;
    m_frames = '0;
    m_records = '0;
  endtask

  // Advance one clock and apply the same edge to the model; returns 1 ns after the edge
  task automatic tick();
    bit acc;
    bit pop;
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      acc = tvalid && m_rdy && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      if (pop) begin
        m_acc = m_acc + mq[0].d[479:416];
        m_records = m_records + 32'd1;
        if (mq[0].l) begin
          m_frames = m_frames + 32'd1;
          m_in_frame = 1'b0;
        end else begin
          m_in_frame = 1'b1;
        end
        void'(mq.pop_front());
      end
      if (acc) mq.push_back('{tdata, tlast});
    end
    m_rdy = 1'b1;
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (tready !== 1'b0) begin
      miscompares++; $display("FAIL reset_tready got %0b want 0", tready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    vectors++;
    if (frame_count !== 32'd0 || record_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", frame_count, record_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++; $display("FAIL release_tready got %0b want 1", tready);
    end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    tvalid = 1'b1;
    tdata = mk($urandom(), 64'd5, 64'h8000_0000);
    tlast = 1'b1;
    tick();
    tvalid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_timestamp !== 64'd5 || out_first !== 1'b1 ||
        out_last !== 1'b1 || out_pc !== 64'h8000_0000) begin
      miscompares++;
      $display("FAIL single_beat got v=%0b ts=%0d f=%0b l=%0b pc=%0h want 1 5 1 1 80000000",
               out_valid, out_timestamp, out_first, out_last, out_pc);
    end
    tick();
    vectors++;
    if (frame_count !== exp_cnt(32'd1) || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_frame_count got %0d v=%0b want %0d v=0", frame_count, out_valid,
               exp_cnt(32'd1));
    end
  endtask

  task automatic test_three_beats();
    logic [63:0] deltas[3] = '{64'd3, 64'd1, 64'd7};
    logic [63:0] stamps[3] = '{64'd3, 64'd4, 64'd11};
    pulse_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tvalid = 1'b1;
      tdata = mk($urandom(), deltas[k], {$urandom(), $urandom()});
      tlast = (k == 2);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_timestamp !== stamps[k] || out_first !== (k == 0) ||
          out_last !== (k == 2)) begin
        miscompares++;
        $display("FAIL three_beats[%0d] got v=%0b ts=%0d f=%0b l=%0b want 1 %0d %0b %0b", k,
                 out_valid, out_timestamp, out_first, out_last, stamps[k], (k == 0), (k == 2));
      end
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    tick();
    vectors++;
    if (record_count !== exp_cnt(32'd3) || out_valid !== 1'b0 || m_in_frame) begin
      miscompares++;
      $display("FAIL three_beats_end got rc=%0d v=%0b want %0d 0", record_count, out_valid,
               exp_cnt(32'd3));
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] sent[$];
    logic [63:0] pc;
    out_ready = 1'b0;
    pc = {$urandom(), $urandom()};
    tdata = mk($urandom(), 64'd2, pc);
    tlast = 1'b0;
    tvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (tready !== (c < 2)) begin
        miscompares++; $display("FAIL bp_tready[%0d] got %0b want %0b", c, tready, (c < 2));
      end
      if (c < 2) sent.push_back(pc);
      tick();
      if (c < 2) begin
        pc = {$urandom(), $urandom()};
        tdata = mk($urandom(), 64'd2, pc);
      end
    end
    tvalid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== sent[k]) begin
        miscompares++;
        $display("FAIL bp_order[%0d] got v=%0b pc=%0h want 1 %0h", k, out_valid, out_pc, sent[k]);
      end
      tick();
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_drained got %0b want 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] deltas[3] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0E, 64'd5};
    pulse_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tvalid = 1'b1;
      tdata = mk($urandom(), deltas[k], {$urandom(), $urandom()});
      tlast = 1'b0;
      tick();
    end
    tvalid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_timestamp !== 64'd3) begin
      miscompares++;
      $display("FAIL wrap_ts got v=%0b ts=%0h want 1 3", out_valid, out_timestamp);
    end
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    tvalid = 1'b1;
    tdata = mk($urandom(), 64'd4, 64'h10);
    tlast = 1'b0;
    tick();
    tvalid = 1'b0;
    tick();
    out_ready = 1'b0;
    tvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tdata = mk($urandom(), 64'd4, 64'h20 + 64'(k));
      tick();
    end
    tdata = mk($urandom(), 64'd4, 64'h99);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tvalid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || tready !== 1'b1 || frame_count !== 32'd0 ||
        record_count !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_state got v=%0b rdy=%0b fc=%0d rc=%0d want 0 1 0 0", out_valid, tready,
               frame_count, record_count);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL clear_drop got v=%0b want 0", out_valid);
    end
    out_ready = 1'b1;
    tvalid = 1'b1;
    tdata = mk($urandom(), 64'd9, 64'h44);
    tlast = 1'b1;
    tick();
    tvalid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_first !== 1'b1 || out_timestamp !== 64'd9 ||
        out_pc !== 64'h44) begin
      miscompares++;
      $display("FAIL clear_next got v=%0b f=%0b ts=%0d pc=%0h want 1 1 9 44", out_valid,
               out_first, out_timestamp, out_pc);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tvalid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tlast = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 49) == 0);
      tdata = mk($urandom(),
                 ($urandom_range(0, 15) == 0) ? {$urandom(), $urandom()} :
                                                64'($urandom_range(0, 100)),
                 {$urandom(), $urandom()});
      tick();
      vectors++;
      if (out_valid !== (mq.size() > 0) || tready !== (m_rdy && mq.size() < 2)) begin
        miscompares++;
        $display("FAIL rnd_hs[%0d] got v=%0b rdy=%0b want %0b %0b", c, out_valid, tready,
                 (mq.size() > 0), (mq.size() < 2));
      end
      if (mq.size() > 0) begin
        vectors++;
        if (out_instr !== mq[0].d[511:480] || out_delta !== mq[0].d[479:416] ||
            out_pc !== mq[0].d[415:352] || out_events !== mq[0].d[351:0] ||
            out_last !== mq[0].l) begin
          miscompares++;
          $display("FAIL rnd_fields[%0d] got instr=%0h pc=%0h l=%0b want %0h %0h %0b", c,
                   out_instr, out_pc, out_last, mq[0].d[511:480], mq[0].d[415:352], mq[0].l);
        end
        vectors++;
        if (out_timestamp !== m_acc + mq[0].d[479:416] || out_first !== !m_in_frame) begin
          miscompares++;
          $display("FAIL rnd_time[%0d] got ts=%0h f=%0b want %0h %0b", c, out_timestamp,
                   out_first, m_acc + mq[0].d[479:416], !m_in_frame);
        end
      end
      vectors++;
      if (frame_count !== exp_cnt(m_frames) || record_count !== exp_cnt(m_records)) begin
        miscompares++;
        $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", c, frame_count, record_count,
                 exp_cnt(m_frames), exp_cnt(m_records));
      end
    end
    clear = 1'b0;
    tvalid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    tvalid = 1'b1;
    tlast = 1'b0;
    tdata = mk($urandom(), 64'd8, 64'h100);
    tick();
    tick();
    out_ready = 1'b0;
    tdata = mk($urandom(), 64'd8, 64'h200);
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    m_rdy = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || tready !== 1'b0 || frame_count !== 32'd0 ||
        record_count !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset got v=%0b rdy=%0b fc=%0d rc=%0d want 0 0 0 0", out_valid,
               tready, frame_count, record_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tvalid = 1'b0;
    tick();
    out_ready = 1'b1;
    tvalid = 1'b1;
    tlast = 1'b1;
    tdata = mk($urandom(), 64'd6, 64'h300);
    tick();
    tvalid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_first !== 1'b1 || out_timestamp !== 64'd6 ||
        out_pc !== 64'h300) begin
      miscompares++;
      $display("FAIL post_reset got v=%0b f=%0b ts=%0d pc=%0h want 1 1 6 300", out_valid,
               out_first, out_timestamp, out_pc);
    end
    tick();
    vectors++;
    if (frame_count !== exp_cnt(32'd1) || record_count !== exp_cnt(32'd1)) begin
      miscompares++;
      $display("FAIL post_reset_counts got %0d/%0d want %0d/%0d", frame_count, record_count,
               exp_cnt(32'd1), exp_cnt(32'd1));
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_three_beats();
    test_backpressure();
    test_wrap();
    test_clear();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
